pong_ctrl: RTL
==============

# pong_ctrl

Per-frame game-state engine for the Pong display path. Once per video frame it advances the ball, moves both paddles from button inputs, detects wall/paddle collisions and misses, keeps score, and sequences serve/play/game-over. Its registered position outputs drive the combinational pixel painter's `ball_x`, `ball_y`, `padl_y` and `padr_y` inputs, which use the same geometry parameters.

## Interface
- `BALL_SIZE`, 20: ball edge length, pixels
- `PAD_HEIGHT`, 100: paddle height
- `PAD_WIDTH`, 10: paddle width
- `PAD_OFFS`, 35: paddle inset from screen edge
- `H_RES`, 1280 / `V_RES`, 800: active resolution
- `BALL_SPEED`, 4: ball step per axis per frame
- `PAD_SPEED`, 6: paddle step per frame
- `SERVE_FRAMES`, 60: serve hold length, frames
- `WIN_SCORE`, 9: points to win, ≤15
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `frame_tick` in 1: single-cycle pulse once per frame (start of vblank)
- `btn_lu`, `btn_ld`, `btn_ru`, `btn_rd` in 1 each: left/right paddle up/down, already synchronised
- `ball_x`, `ball_y` out 11: ball top-left corner
- `padl_y`, `padr_y` out 11: paddle top edges
- `score_l`, `score_r` out 4: points
- `game_over` out 1: high in OVER

## Operation
- Reset: state SERVE, serve_cnt=SERVE_FRAMES, ball=(630,390) i.e. ((H_RES−BALL_SIZE)/2,(V_RES−BALL_SIZE)/2), dx=right, dy=down, paddles=350, scores 0, game_over 0.
- All updates only on cycles with `frame_tick`=1; otherwise every register holds.
- Paddles (SERVE and PLAY): up-only → max(y−PAD_SPEED,0); down-only → min(y+PAD_SPEED,V_RES−PAD_HEIGHT); both or neither → hold. Frozen in OVER.
- SERVE: ball held at centre; serve_cnt≠0 → decrement; serve_cnt=0 → PLAY.
- PLAY vertical: up and ball_y≤BALL_SPEED → ball_y=0, dy=down; down and ball_y+BALL_SIZE+BALL_SPEED≥V_RES → ball_y=V_RES−BALL_SIZE, dy=up; else step.
- PLAY left (dx=left): face L=PAD_OFFS+PAD_WIDTH=45. Hit if ball_x≥L, ball_x−BALL_SPEED<L, ball_y+BALL_SIZE>padl_y, ball_y<padl_y+PAD_HEIGHT → ball_x=L, dx=right. Else ball_x≤BALL_SPEED → miss, right scores. Else step.
- PLAY right: face R=H_RES−PAD_OFFS−PAD_WIDTH−1=1234. Hit if ball_x+BALL_SIZE≤R, ball_x+BALL_SIZE+BALL_SPEED>R, vertical overlap with padr → ball_x=R−BALL_SIZE=1214, dx=left. Else ball_x+BALL_SIZE+BALL_SPEED≥H_RES → miss, left scores. Else step.
- Collision tests use pre-update paddle positions. Vertical bounce and paddle hit in one tick both apply.
- Miss: scorer +1; ball centred; dx toward conceding player, dy unchanged; if new score=WIN_SCORE → OVER, else SERVE with serve_cnt=SERVE_FRAMES. Miss overrides vertical update that tick.
- OVER: all outputs hold, game_over=1. Tick with any button high → scores 0, ball and paddles to reset values, dx=right, dy=down, SERVE with serve_cnt=SERVE_FRAMES.
- Comparisons in 12-bit unsigned to avoid wrap; outputs never leave on-screen bounds.

## Timing
- All outputs registered; they change in the cycle after the `frame_tick` cycle and stay stable for the rest of the frame.
- One tick = exactly one update; no multi-cycle pipeline; `frame_tick` high for N consecutive cycles counts as N frames.
- `rst` wins over `frame_tick` in the same cycle; reset mid-rally discards state.
- After reset: ticks 1–60 count down, tick 61 enters PLAY, tick 62 is the first ball move.

## Structure
- Shared package `pong_pkg`: default geometry constants, derived faces L/R, centre coordinates, state enum {SERVE, PLAY, OVER}, direction encoding.
- Sub-module `pad_ctrl` (instantiated twice): up/down clamped paddle register, enabled by tick and state.

## Test plan
- Reset then 62 ticks, no buttons → ball (630,390) through tick 61, (634,394) after tick 62; paddles 350.
- Hold `btn_lu` 60 ticks → padl_y 344, 338 … 2, then clamps 0; `btn_rd` alone → padr_y clamps at 700; both left buttons → padl_y holds.
- Ball moving down at ball_y=777 → next tick ball_y=780, dy=up; next ball_y=776.
- Ball dx=left at ball_x=47, ball_y=380, padl_y=350 → ball_x=45, dx=right; same with padl_y=500 → no hit, ball travels to x≤4, score_r=1, ball (630,390), dx=left, SERVE.
- Right-paddle hit with ball at ball_x=1212 and simultaneous top-wall bounce → ball_x=1214, dx=left, ball_y=0, dy=down.
- score_l=8, left scores → score_l=9, game_over=1, outputs frozen for 100 ticks; tick with `btn_ru` → scores 0, game_over 0, SERVE; `rst` during PLAY → reset values next cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong geometry defaults, state and direction encodings, and helpers
// for the derived paddle faces and centre coordinates.
package pong_pkg;

  localparam int DEF_BALL_SIZE    = 20;
  localparam int DEF_PAD_HEIGHT   = 100;
  localparam int DEF_PAD_WIDTH    = 10;
  localparam int DEF_PAD_OFFS     = 35;
  localparam int DEF_H_RES        = 1280;
  localparam int DEF_V_RES        = 800;
  localparam int DEF_BALL_SPEED   = 4;
  localparam int DEF_PAD_SPEED    = 6;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_WIN_SCORE    = 9;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // DIR_NEG moves toward coordinate 0 (left / up).
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  function automatic int face_l(input int offs, input int width);
    return offs + width;
  endfunction

  function automatic int face_r(input int h_res, input int offs, input int width);
    return h_res - offs - width - 1;
  endfunction

  function automatic int centre(input int res, input int size);
    return (res - size) / 2;
  endfunction

  function automatic logic [11:0] ext12(input logic [10:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_ctrl_pad.sv
// One paddle: vertical position register stepped by the up/down buttons on
// enabled frame ticks and clamped to the screen; restart reloads the centre.
module pad_ctrl
  import pong_pkg::*;
#(
  parameter int PAD_SPEED  = DEF_PAD_SPEED,
  parameter int PAD_HEIGHT = DEF_PAD_HEIGHT,
  parameter int V_RES      = DEF_V_RES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_en,
  input  logic        restart,
  input  logic        btn_up,
  input  logic        btn_dn,
  output logic [10:0] y
);

  localparam logic [11:0] SPD   = 12'(PAD_SPEED);
  localparam logic [11:0] Y_MAX = 12'(V_RES - PAD_HEIGHT);
  localparam logic [10:0] Y0    = 11'(centre(V_RES, PAD_HEIGHT));

  logic [10:0] y_q, y_d;
  logic [11:0] y_w;

  always_comb begin
    y_w = ext12(y_q);
    y_d = y_q;
    if (restart) begin
      y_d = Y0;
    end else if (move_en && (btn_up != btn_dn)) begin
      if (btn_up) begin
        y_d = (y_w >= SPD) ? 11'(y_w - SPD) : 11'd0;
      end else begin
        y_d = (y_w + SPD >= Y_MAX) ? 11'(Y_MAX) : 11'(y_w + SPD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= Y0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/pong_ctrl.sv
// Per-frame Pong engine: ball motion, wall/paddle collisions, scoring and the
// SERVE/PLAY/OVER sequence, all advanced once per frame_tick.
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PAD_HEIGHT   = DEF_PAD_HEIGHT,
  parameter int PAD_WIDTH    = DEF_PAD_WIDTH,
  parameter int PAD_OFFS     = DEF_PAD_OFFS,
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int PAD_SPEED    = DEF_PAD_SPEED,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_lu,
  input  logic        btn_ld,
  input  logic        btn_ru,
  input  logic        btn_rd,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] padl_y,
  output logic [10:0] padr_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic [11:0] SZ   = 12'(BALL_SIZE);
  localparam logic [11:0] BSPD = 12'(BALL_SPEED);
  localparam logic [11:0] PH   = 12'(PAD_HEIGHT);
  localparam logic [11:0] HR   = 12'(H_RES);
  localparam logic [11:0] VR   = 12'(V_RES);
  localparam logic [11:0] FL   = 12'(face_l(PAD_OFFS, PAD_WIDTH));
  localparam logic [11:0] FR   = 12'(face_r(H_RES, PAD_OFFS, PAD_WIDTH));
  localparam logic [10:0] CX   = 11'(centre(H_RES, BALL_SIZE));
  localparam logic [10:0] CY   = 11'(centre(V_RES, BALL_SIZE));
  localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
  localparam int          CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SERVE_FRAMES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [10:0]        ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  dir_t               dx_q, dx_d, dy_q, dy_d;
  logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic               game_over_q, game_over_d;

  logic [11:0] bx, by, pl, pr;
  logic        ovl_l, ovl_r, miss_l, miss_r, restart, move_en;
  logic [10:0] x_nxt, y_nxt;
  dir_t        dx_nxt, dy_nxt;
  logic [3:0]  sl_inc, sr_inc;

  // Candidate PLAY motion, evaluated against the pre-update paddle positions.
  always_comb begin
    bx = ext12(ball_x_q);
    by = ext12(ball_y_q);
    pl = ext12(padl_y);
    pr = ext12(padr_y);
    ovl_l = (by + SZ > pl) && (by < pl + PH);
    ovl_r = (by + SZ > pr) && (by < pr + PH);

    y_nxt  = ball_y_q;
    dy_nxt = dy_q;
    if (dy_q == DIR_NEG) begin
      if (by <= BSPD) begin
        y_nxt  = 11'd0;
        dy_nxt = DIR_POS;
      end else begin
        y_nxt = 11'(by - BSPD);
      end
    end else if (by + SZ + BSPD >= VR) begin
      y_nxt  = 11'(VR - SZ);
      dy_nxt = DIR_NEG;
    end else begin
      y_nxt = 11'(by + BSPD);
    end

    x_nxt  = ball_x_q;
    dx_nxt = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (dx_q == DIR_NEG) begin
      if (bx >= FL && bx - BSPD < FL && ovl_l) begin
        x_nxt  = 11'(FL);
        dx_nxt = DIR_POS;
      end else if (bx <= BSPD) begin
        miss_l = 1'b1;
      end else begin
        x_nxt = 11'(bx - BSPD);
      end
    end else begin
      if (bx + SZ <= FR && bx + SZ + BSPD > FR && ovl_r) begin
        x_nxt  = 11'(FR - SZ);
        dx_nxt = DIR_NEG;
      end else if (bx + SZ + BSPD >= HR) begin
        miss_r = 1'b1;
      end else begin
        x_nxt = 11'(bx + BSPD);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    restart     = 1'b0;
    sl_inc      = score_l_q + 4'd1;
    sr_inc      = score_r_q + 4'd1;
    if (frame_tick) begin
      case (state_q)
        ST_SERVE: begin
          if (serve_cnt_q != '0) serve_cnt_d = serve_cnt_q - CNT_W'(1);
          else                   state_d     = ST_PLAY;
        end
        ST_PLAY: begin
          // A miss recentres the ball and discards this tick's vertical step.
          if (miss_l || miss_r) begin
            ball_x_d    = CX;
            ball_y_d    = CY;
            serve_cnt_d = CNT_INIT;
            if (miss_l) begin
              score_r_d = sr_inc;
              dx_d      = DIR_NEG;
              state_d   = (sr_inc == WIN) ? ST_OVER : ST_SERVE;
            end else begin
              score_l_d = sl_inc;
              dx_d      = DIR_POS;
              state_d   = (sl_inc == WIN) ? ST_OVER : ST_SERVE;
            end
          end else begin
            ball_x_d = x_nxt;
            ball_y_d = y_nxt;
            dx_d     = dx_nxt;
            dy_d     = dy_nxt;
          end
        end
        ST_OVER: begin
          if (btn_lu || btn_ld || btn_ru || btn_rd) begin
            restart     = 1'b1;
            state_d     = ST_SERVE;
            serve_cnt_d = CNT_INIT;
            ball_x_d    = CX;
            ball_y_d    = CY;
            dx_d        = DIR_POS;
            dy_d        = DIR_POS;
            score_l_d   = 4'd0;
            score_r_d   = 4'd0;
          end
        end
        default: state_d = ST_SERVE;
      endcase
    end
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      serve_cnt_q <= CNT_INIT;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_POS;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
    end
  end

  assign move_en = frame_tick && (state_q != ST_OVER);

  pad_ctrl #(.PAD_SPEED(PAD_SPEED), .PAD_HEIGHT(PAD_HEIGHT), .V_RES(V_RES)) u_pad_l (
    .clk     (clk),
    .rst     (rst),
    .move_en (move_en),
    .restart (restart),
    .btn_up  (btn_lu),
    .btn_dn  (btn_ld),
    .y       (padl_y)
  );

  pad_ctrl #(.PAD_SPEED(PAD_SPEED), .PAD_HEIGHT(PAD_HEIGHT), .V_RES(V_RES)) u_pad_r (
    .clk     (clk),
    .rst     (rst),
    .move_en (move_en),
    .restart (restart),
    .btn_up  (btn_ru),
    .btn_dn  (btn_rd),
    .y       (padr_y)
  );

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule
